cnn: RTL and testbench



---
 rtl/cnn_pkg.sv | 48 ++++
 rtl/cnn_kernel_dot.sv | 16 +
 rtl/cnn.sv | 178 +++++++++++++++++
 tb/tb_cnn.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared sizes, state encoding and signed data types for the cnn inference block.
package cnn_pkg;

  localparam int IMAGE_WIDTH               = 12;
  localparam int IMAGE_HEIGHT              = 12;
  localparam int NUM_FEATURES              = 2;
  localparam int KERNEL_SIZE               = 3;
  localparam int KERNEL_AREA               = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CONVOLUTION_WIDTH         = IMAGE_WIDTH - KERNEL_SIZE + 1;
  localparam int CONVOLUTION_HEIGHT        = IMAGE_HEIGHT - KERNEL_SIZE + 1;
  localparam int POOLED_WIDTH              = CONVOLUTION_WIDTH / 2;
  localparam int POOLED_HEIGHT             = CONVOLUTION_HEIGHT / 2;
  localparam int FLATTENED_LENGTH          = NUM_FEATURES * POOLED_WIDTH * POOLED_HEIGHT;
  localparam int CONVOLUTION_DATA_WIDTH    = 8;
  localparam int FULLYCONNECTED_DATA_WIDTH = 8;
  localparam int OUTPUT_DATA_WIDTH         = 32;

  localparam int FEAT_ADDR_W = $clog2(NUM_FEATURES) + 1;
  localparam int FEAT_IDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int IMG_ROW_W   = $clog2(IMAGE_HEIGHT);
  localparam int IMG_COL_W   = $clog2(IMAGE_WIDTH);
  localparam int CROW_W      = $clog2(CONVOLUTION_HEIGHT);
  localparam int CCOL_W      = $clog2(CONVOLUTION_WIDTH);
  localparam int PROW_W      = $clog2(POOLED_HEIGHT);
  localparam int PCOL_W      = $clog2(POOLED_WIDTH);
  localparam int FC_IDX_W    = $clog2(FLATTENED_LENGTH);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    CONVOLUTION    = 3'd1,
    POOLING        = 3'd2,
    FLATTENING     = 3'd3,
    FULLYCONNECTED = 3'd4,
    OUTPUT         = 3'd5
  } state_t;

  typedef logic signed [1:0]                           pix_t;
  typedef logic signed [1:0]                           wgt_t;
  typedef logic signed [CONVOLUTION_DATA_WIDTH-1:0]    conv_t;
  typedef logic signed [CONVOLUTION_DATA_WIDTH-1:0]    fcw_t;
  typedef logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] fc_prod_t;
  typedef logic signed [OUTPUT_DATA_WIDTH-1:0]         acc_t;

  function automatic conv_t max2(input conv_t a, input conv_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_kernel_dot.sv
// Combinational signed dot product of one image window with one kernel.
module cnn_kernel_dot
  import cnn_pkg::*;
(
  input  pix_t [KERNEL_AREA-1:0] window,
  input  wgt_t [KERNEL_AREA-1:0] kernel,
  output conv_t                  dot
);

  always_comb begin
    dot = '0;
    for (int k = 0; k < KERNEL_AREA; k++)
      dot = dot + conv_t'(window[k]) * conv_t'(kernel[k]);
  end

endmodule

// File: rtl/cnn.sv
// CNN inference top: conv -> 2x2 max pool -> flatten -> single-neuron FC, one step per cycle.
module cnn
  import cnn_pkg::*;
(
  input  logic                                                  clk,
  input  logic                                                  rst_cnn,
  input  logic                                                  rst_feature_weights,
  input  logic                                                  rst_fullyconnected_weights,
  input  pix_t [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0]              image_input,
  input  wgt_t [KERNEL_AREA-1:0]                                feature_weights_input,
  input  logic [FEAT_ADDR_W-1:0]                                feature_writeAddr,
  input  logic                                                  feature_WrEn,
  input  logic [FLATTENED_LENGTH-1:0][CONVOLUTION_DATA_WIDTH-1:0] fullyconnected_weights_input,
  input  logic                                                  fullyconnected_WrEn,
  input  logic                                                  convolution_enable,
  output logic [OUTPUT_DATA_WIDTH-1:0]                          cnn_output
);

  localparam logic [CROW_W-1:0]   CROW_LAST = CROW_W'(CONVOLUTION_HEIGHT - 1);
  localparam logic [CCOL_W-1:0]   CCOL_LAST = CCOL_W'(CONVOLUTION_WIDTH - 1);
  localparam logic [PROW_W-1:0]   PROW_LAST = PROW_W'(POOLED_HEIGHT - 1);
  localparam logic [PCOL_W-1:0]   PCOL_LAST = PCOL_W'(POOLED_WIDTH - 1);
  localparam logic [FC_IDX_W-1:0] FC_LAST   = FC_IDX_W'(FLATTENED_LENGTH - 1);
  localparam logic [FEAT_ADDR_W-1:0] FEAT_LIMIT = FEAT_ADDR_W'(NUM_FEATURES);

  state_t state, next_state;

  wgt_t [NUM_FEATURES-1:0][KERNEL_AREA-1:0]   kernel_mem;
  fcw_t                                       fc_weights [FLATTENED_LENGTH];
  pix_t [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0]   image_q;

  conv_t convolution_outfmap [NUM_FEATURES][CONVOLUTION_HEIGHT][CONVOLUTION_WIDTH];
  conv_t pooled_outfmap      [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH];
  conv_t flattened_outfmap   [FLATTENED_LENGTH];

  logic [CROW_W-1:0]   conv_row;
  logic [CCOL_W-1:0]   conv_col;
  logic [PROW_W-1:0]   pool_row;
  logic [PCOL_W-1:0]   pool_col;
  logic [FC_IDX_W-1:0] fc_idx;
  acc_t                acc;
  acc_t                out_q;

  pix_t [KERNEL_AREA-1:0] window;
  conv_t                  dot      [NUM_FEATURES];
  conv_t                  pool_max [NUM_FEATURES];

  logic conv_last, pool_last, fc_last;
  assign conv_last = (conv_row == CROW_LAST) && (conv_col == CCOL_LAST);
  assign pool_last = (pool_row == PROW_LAST) && (pool_col == PCOL_LAST);
  assign fc_last   = (fc_idx == FC_LAST);

  // Weight memories are writable in any state; their resets win over a write.
  always_ff @(posedge clk) begin
    if (rst_feature_weights)
      kernel_mem <= '0;
    else if (!feature_WrEn && (feature_writeAddr < FEAT_LIMIT))
      kernel_mem[feature_writeAddr[FEAT_IDX_W-1:0]] <= feature_weights_input;
  end

  always_ff @(posedge clk) begin
    if (rst_fullyconnected_weights) begin
      for (int k = 0; k < FLATTENED_LENGTH; k++) fc_weights[k] <= '0;
    end else if (!fullyconnected_WrEn) begin
      for (int k = 0; k < FLATTENED_LENGTH; k++)
        fc_weights[k] <= $signed(fullyconnected_weights_input[k]);
    end
  end

  // Window of the latched image anchored at the current convolution position.
  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_win_r
    for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_win_c
      assign window[i*KERNEL_SIZE + j] =
        image_q[IMG_ROW_W'(conv_row) + IMG_ROW_W'(i)][IMG_COL_W'(conv_col) + IMG_COL_W'(j)];
    end
  end

  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
    cnn_kernel_dot u_dot (
      .window (window),
      .kernel (kernel_mem[f]),
      .dot    (dot[f])
    );
  end

  always_comb begin
    for (int f = 0; f < NUM_FEATURES; f++) begin
      pool_max[f] = max2(
        max2(convolution_outfmap[f][{pool_row, 1'b0}][{pool_col, 1'b0}],
             convolution_outfmap[f][{pool_row, 1'b0}][{pool_col, 1'b1}]),
        max2(convolution_outfmap[f][{pool_row, 1'b1}][{pool_col, 1'b0}],
             convolution_outfmap[f][{pool_row, 1'b1}][{pool_col, 1'b1}]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_cnn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:           if (!convolution_enable) next_state = CONVOLUTION;
      CONVOLUTION:    if (conv_last)           next_state = POOLING;
      POOLING:        if (pool_last)           next_state = FLATTENING;
      FLATTENING:                              next_state = FULLYCONNECTED;
      FULLYCONNECTED: if (fc_last)             next_state = OUTPUT;
      OUTPUT:                                  next_state = IDLE;
      default:                                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      image_q  <= '0;
      conv_row <= '0;
      conv_col <= '0;
      pool_row <= '0;
      pool_col <= '0;
      fc_idx   <= '0;
      acc      <= '0;
      out_q    <= '0;
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int r = 0; r < CONVOLUTION_HEIGHT; r++)
          for (int c = 0; c < CONVOLUTION_WIDTH; c++)
            convolution_outfmap[f][r][c] <= '0;
        for (int r = 0; r < POOLED_HEIGHT; r++)
          for (int c = 0; c < POOLED_WIDTH; c++)
            pooled_outfmap[f][r][c] <= '0;
      end
      for (int k = 0; k < FLATTENED_LENGTH; k++) flattened_outfmap[k] <= '0;
    end else begin
      case (state)
        IDLE: if (!convolution_enable) image_q <= image_input;
        CONVOLUTION: begin
          for (int f = 0; f < NUM_FEATURES; f++)
            convolution_outfmap[f][conv_row][conv_col] <= dot[f];
          if (conv_col == CCOL_LAST) begin
            conv_col <= '0;
            conv_row <= (conv_row == CROW_LAST) ? '0 : conv_row + 1'b1;
          end else begin
            conv_col <= conv_col + 1'b1;
          end
        end
        POOLING: begin
          for (int f = 0; f < NUM_FEATURES; f++)
            pooled_outfmap[f][pool_row][pool_col] <= pool_max[f];
          if (pool_col == PCOL_LAST) begin
            pool_col <= '0;
            pool_row <= (pool_row == PROW_LAST) ? '0 : pool_row + 1'b1;
          end else begin
            pool_col <= pool_col + 1'b1;
          end
        end
        FLATTENING: begin
          for (int f = 0; f < NUM_FEATURES; f++)
            for (int r = 0; r < POOLED_HEIGHT; r++)
              for (int c = 0; c < POOLED_WIDTH; c++)
                flattened_outfmap[f*POOLED_HEIGHT*POOLED_WIDTH + r*POOLED_WIDTH + c]
                  <= pooled_outfmap[f][r][c];
          // Accumulator is cleared on the way into the MAC phase.
          acc    <= '0;
          fc_idx <= '0;
        end
        FULLYCONNECTED: begin
          acc    <= acc + acc_t'(flattened_outfmap[fc_idx]) * acc_t'(fc_weights[fc_idx]);
          fc_idx <= fc_last ? '0 : fc_idx + 1'b1;
        end
        OUTPUT: out_q <= acc;
        default: ;
      endcase
    end
  end

  assign cnn_output = out_q;

endmodule

// File: tb/tb_cnn.sv
// Directed bench for cnn: array-arithmetic reference model, per-cycle output monitor, latency/map checks.
module tb_cnn;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_cnn, rst_feature_weights, rst_fullyconnected_weights;
  pix_t [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] image_input;
  wgt_t [KERNEL_AREA-1:0] feature_weights_input;
  logic [FEAT_ADDR_W-1:0] feature_writeAddr;
  logic feature_WrEn, fullyconnected_WrEn, convolution_enable;
  logic [FLATTENED_LENGTH-1:0][CONVOLUTION_DATA_WIDTH-1:0] fullyconnected_weights_input;
  logic [OUTPUT_DATA_WIDTH-1:0] cnn_output;

  cnn dut (
    .clk                          (clk),
    .rst_cnn                      (rst_cnn),
    .rst_feature_weights          (rst_feature_weights),
    .rst_fullyconnected_weights   (rst_fullyconnected_weights),
    .image_input                  (image_input),
    .feature_weights_input        (feature_weights_input),
    .feature_writeAddr            (feature_writeAddr),
    .feature_WrEn                 (feature_WrEn),
    .fullyconnected_weights_input (fullyconnected_weights_input),
    .fullyconnected_WrEn          (fullyconnected_WrEn),
    .convolution_enable           (convolution_enable),
    .cnn_output                   (cnn_output)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_out = '0;
  bit mon_en = 0;

  int img [12][12];
  int ker [2][9];
  int fcw [50];
  int m_conv [2][10][10];
  int m_pool [2][5][5];
  int m_flat [50];
  int m_out;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cnn_output must match the last completed inference (or 0 after reset) on every cycle.
  always @(negedge clk)
    if (mon_en) check("cnn_output_hold", $signed(cnn_output), $signed(exp_out));

  task automatic compute_model();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) begin
          int s = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) s += img[r+i][c+j] * ker[f][i*3+j];
          m_conv[f][r][c] = s;
        end
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          int m = m_conv[f][2*r][2*c];
          if (m_conv[f][2*r][2*c+1]   > m) m = m_conv[f][2*r][2*c+1];
          if (m_conv[f][2*r+1][2*c]   > m) m = m_conv[f][2*r+1][2*c];
          if (m_conv[f][2*r+1][2*c+1] > m) m = m_conv[f][2*r+1][2*c+1];
          m_pool[f][r][c] = m;
          m_flat[f*25 + r*5 + c] = m;
        end
    m_out = 0;
    for (int k = 0; k < 50; k++) m_out += m_flat[k] * fcw[k];
  endtask

  task automatic write_kernel(input int addr, input int kv [9]);
    for (int k = 0; k < 9; k++) feature_weights_input[k] = wgt_t'(kv[k]);
    feature_writeAddr = FEAT_ADDR_W'(addr);
    feature_WrEn = 1'b0;
    @(posedge clk); #1;
    feature_WrEn = 1'b1;
  endtask

  task automatic write_fc(input int v);
    for (int k = 0; k < 50; k++) begin
      fullyconnected_weights_input[k] = 8'(v);
      fcw[k] = v;
    end
    fullyconnected_WrEn = 1'b0;
    @(posedge clk); #1;
    fullyconnected_WrEn = 1'b1;
  endtask

  task automatic run(input bit busy_pulse, input int lit);
    int seen [6];
    int s;
    for (int i = 0; i < 6; i++) seen[i] = -1;
    compute_model();
    check("model_pin", m_out, lit);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) image_input[r][c] = pix_t'(img[r][c]);
    convolution_enable = 1'b0;
    @(posedge clk); #1;
    convolution_enable = 1'b1;
    check("start_state", int'(dut.state), 1);
    for (int cyc = 1; cyc <= 300 && seen[0] < 0; cyc++) begin
      if (busy_pulse && cyc == 50) convolution_enable = 1'b0;
      @(posedge clk); #1;
      convolution_enable = 1'b1;
      s = int'(dut.state);
      if (s >= 0 && s < 6 && seen[s] < 0) seen[s] = cyc;
      if (cyc == 100)
        for (int f = 0; f < 2; f++) begin
          check("conv_00", dut.convolution_outfmap[f][0][0], m_conv[f][0][0]);
          check("conv_01", dut.convolution_outfmap[f][0][1], m_conv[f][0][1]);
          check("conv_99", dut.convolution_outfmap[f][9][9], m_conv[f][9][9]);
        end
      if (cyc == 125)
        for (int f = 0; f < 2; f++) begin
          check("pool_00", dut.pooled_outfmap[f][0][0], m_pool[f][0][0]);
          check("pool_23", dut.pooled_outfmap[f][2][3], m_pool[f][2][3]);
          check("pool_44", dut.pooled_outfmap[f][4][4], m_pool[f][4][4]);
        end
      if (cyc == 126) begin
        check("flat_0",  dut.flattened_outfmap[0],  m_flat[0]);
        check("flat_24", dut.flattened_outfmap[24], m_flat[24]);
        check("flat_25", dut.flattened_outfmap[25], m_flat[25]);
        check("flat_49", dut.flattened_outfmap[49], m_flat[49]);
      end
      if (s == 0) exp_out = 32'(m_out);
    end
    check("lat_pooling",  seen[2], 100);
    check("lat_flatten",  seen[3], 125);
    check("lat_fc",       seen[4], 126);
    check("lat_output",   seen[5], 176);
    check("lat_idle",     seen[0], 177);
    check("result_model", $signed(cnn_output), m_out);
    check("result_lit",   $signed(cnn_output), lit);
  endtask

  int kx   [9] = '{1, -1, 1, -1, 1, -1, 1, -1, 1};
  int kone [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int kbad [9] = '{-2, -2, -2, -2, -2, -2, -2, -2, -2};

  initial begin
    rst_cnn = 1'b1; rst_feature_weights = 1'b1; rst_fullyconnected_weights = 1'b1;
    image_input = '0; feature_weights_input = '0; feature_writeAddr = '0;
    feature_WrEn = 1'b1; fullyconnected_WrEn = 1'b1; convolution_enable = 1'b1;
    fullyconnected_weights_input = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_cnn = 1'b0; rst_feature_weights = 1'b0; rst_fullyconnected_weights = 1'b0;
    check("reset_state", int'(dut.state), 0);
    check("reset_output", $signed(cnn_output), 0);
    mon_en = 1;

    // All-ones image, X and box kernels, unit FC weights.
    for (int r = 0; r < 12; r++) for (int c = 0; c < 12; c++) img[r][c] = 1;
    ker[0] = kx; ker[1] = kone;
    write_kernel(0, kx);
    write_kernel(1, kone);
    write_fc(1);
    run(0, 250);
    check("pin_pool_f0", m_pool[0][1][1], 1);
    check("pin_pool_f1", m_pool[1][3][2], 9);

    write_fc(-1);
    run(0, -250);

    for (int r = 0; r < 12; r++) for (int c = 0; c < 12; c++) img[r][c] = -1;
    write_fc(1);
    run(0, -250);
    check("pin_conv_neg", m_conv[1][5][5], -9);

    for (int r = 0; r < 12; r++) for (int c = 0; c < 12; c++) img[r][c] = ((r + c) % 2 == 0) ? 1 : 0;
    run(0, 250);
    check("pin_chk_even", m_conv[0][0][0], 5);
    check("pin_chk_odd",  m_conv[0][0][1], -4);
    check("pin_chk_pool", m_pool[0][2][2], 5);

    // Out-of-range slot must not alias onto a real kernel; busy start pulse is ignored.
    write_kernel(2, kbad);
    run(1, 250);

    // Abort mid-convolution.
    convolution_enable = 1'b0;
    @(posedge clk); #1;
    convolution_enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_cnn = 1'b1;
    @(posedge clk); #1;
    rst_cnn = 1'b0;
    exp_out = '0;
    check("abort_state", int'(dut.state), 0);
    check("abort_output", $signed(cnn_output), 0);
    check("abort_map", dut.convolution_outfmap[0][0][0], 0);
    run(0, 250);

    // FC reset beats a simultaneous write.
    for (int k = 0; k < 50; k++) fullyconnected_weights_input[k] = 8'd3;
    fullyconnected_WrEn = 1'b0;
    rst_fullyconnected_weights = 1'b1;
    @(posedge clk); #1;
    fullyconnected_WrEn = 1'b1;
    rst_fullyconnected_weights = 1'b0;
    for (int k = 0; k < 50; k++) fcw[k] = 0;
    run(0, 0);

    @(posedge clk); #1;
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
